button_ctrl: RTL and testbench
==============================

// Module: button_ctrl
// PURPOSE
// Front-end control stage feeding the LED pattern FSM. Synchronises and debounces
// two raw push buttons (enable, direction) and converts each press into a toggled
// level output plus a one-cycle pulse. Also generates a single-cycle step_tick
// clock-enable that replaces a divided clock for downstream FSM state updates.
// PARAMETERS
// DIV_N     25  step_tick period = 2**DIV_N clk cycles (counts only while en=1)
// SAMPLE_N  16  debounce sample period = 2**SAMPLE_N clk cycles (0 = every cycle)
// DEB_N     4   consecutive equal samples required to change a debounced level
// PORTS
// clk        in   1  system clock, all state on posedge
// rst        in   1  synchronous reset, ACTIVE-LOW (rst==0 at posedge clears all)
// btn_en     in   1  raw, asynchronous, bouncy enable button (1 = pressed)
// btn_dir    in   1  raw, asynchronous, bouncy direction button (1 = pressed)
// en         out  1  enable level, toggles once per debounced btn_en press
// dir        out  1  direction level, toggles once per debounced btn_dir press
// en_pulse   out  1  one-cycle pulse on each debounced btn_en press
// dir_pulse  out  1  one-cycle pulse on each debounced btn_dir press
// step_tick  out  1  one-cycle clock-enable for the downstream FSM
// BEHAVIOUR
// - Reset (rst==0): en=0, dir=0, en_pulse=0, dir_pulse=0, step_tick=0; sync flops,
//   shift regs, debounced levels, sample and step counters all 0; FSMs -> RELEASED.
//   Reset mid-press: button must be seen released (debounced 0) before a new pulse.
// - Sync: 2-flop synchroniser per button; nothing else uses the raw inputs.
// - Sample counter: SAMPLE_N bits, free-running; samp = (cnt == all-ones); SAMPLE_N=0
//   -> samp=1 every cycle.
// - Debounce: per button DEB_N-bit shift reg, shifts in synced bit on samp.
//   Debounced level <= 1 when reg all-ones, <= 0 when all-zeros, else holds.
// - Per-button FSM, 2 states:
//   RELEASED: debounced==1 -> PRESSED, assert pulse for exactly this one transition.
//   PRESSED : debounced==0 -> RELEASED, no pulse. Holding never re-pulses.
// - Pulse and level are registered on the same edge: on FSM RELEASED->PRESSED edge,
//   *_pulse<=1 and level<=~level; pulse <=0 on the following edge.
// - Latency (SAMPLE_N=0): raw held 1 from edge k -> pulse high after edge k+DEB_N+3.
// - en and dir are fully independent; simultaneous presses both pulse in same cycle.
// - Step counter: DIV_N bits, increments only while en==1, holds when en==0 (no clear).
//   step_tick=1 for one cycle when counter wraps all-ones->0 with en==1; never
//   while en==0. First tick after reset+enable: 2**DIV_N cycles after en rises.
// - dir toggling does not affect step counter or step_tick.
// - Bounce shorter than DEB_N samples produces no pulse and no level change.
// TESTING
// (Bench overrides: DIV_N=3, SAMPLE_N=0, DEB_N=3.)
// 1 Reset: rst=0 2 cycles, buttons toggling -> all outputs 0; rst=1 -> outputs stay 0.
// 2 Clean press: btn_en 0->1 held 20 cycles -> en_pulse high exactly 1 cycle, 6 edges
//   after rise; en 0->1 same edge; no further pulse while held; release -> no pulse.
// 3 Bounce: btn_dir pattern 1,0,1,1,0,1,0 then 0 -> no dir_pulse, dir stays 0;
//   then 1 held 5 cycles -> one dir_pulse, dir=1.
// 4 Step tick: en=1 -> step_tick every 8 cycles, 1 cycle wide; press en again ->
//   en=0, no ticks; re-enable -> ticks resume from held count (gap <8 cycles).
// 5 Simultaneous: both buttons rise same cycle -> en_pulse & dir_pulse same cycle,
//   en and dir both toggle.
// 6 Reset mid-op: en=1, counter=5, btn_en held 1, rst=0 one cycle -> en=0, no tick;
//   with btn_en still held after reset -> no pulse until released and re-pressed.

Source files
------------

// File: rtl/button_ctrl.sv
// ============================================================================
// button_ctrl
// ----------------------------------------------------------------------------
// Front-end control stage for the LED pattern FSM.
//   * Synchronises (2 flops) and debounces the two raw push buttons.
//   * Turns each debounced press into a toggled level plus a one-cycle pulse.
//   * Generates step_tick, a one-cycle clock-enable every 2**DIV_N cycles
//     while the enable level is high. The downstream FSM uses it instead of
//     a divided clock.
//
// Parameters
//   DIV_N     step_tick period is 2**DIV_N clk cycles (counts only while en=1)
//   SAMPLE_N  debounce sample period is 2**SAMPLE_N cycles (0 = every cycle)
//   DEB_N     consecutive equal samples needed to change a debounced level
//
// Ports
//   clk        in   system clock, all state on posedge
//   rst        in   synchronous reset, active low
//   btn_en     in   raw asynchronous enable button (1 = pressed)
//   btn_dir    in   raw asynchronous direction button (1 = pressed)
//   en         out  enable level, toggles once per debounced btn_en press
//   dir        out  direction level, toggles once per debounced btn_dir press
//   en_pulse   out  one-cycle pulse per debounced btn_en press
//   dir_pulse  out  one-cycle pulse per debounced btn_dir press
//   step_tick  out  one-cycle clock-enable for the downstream FSM
// ============================================================================
module button_ctrl #(
   parameter int DIV_N    = 25,
   parameter int SAMPLE_N = 16,
   parameter int DEB_N    = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_en,
   input  logic btn_dir,
   output logic en,
   output logic dir,
   output logic en_pulse,
   output logic dir_pulse,
   output logic step_tick
);

   localparam logic [0:0] ST_RELEASED = 1'b0;
   localparam logic [0:0] ST_PRESSED  = 1'b1;

   // Number of samples after reset before a debounce shift register holds
   // only genuine input history. Two samples can still see the cleared
   // synchroniser flops, and DEB_N more are needed to fill the register.
   localparam int PRIME_CNT = DEB_N + 2;
   localparam int PRIME_W   = $clog2(PRIME_CNT + 1);

   // ------------------------------------------------------------------------
   // Debounce sample strobe
   // ------------------------------------------------------------------------
   logic samp;

   generate
      if (SAMPLE_N == 0) begin : g_samp_every
         assign samp = 1'b1;
      end else begin : g_samp_cnt
         logic [SAMPLE_N-1:0] samp_cnt_q;

         always_ff @(posedge clk) begin
            if (!rst) begin
               samp_cnt_q <= '0;
            end else begin
               samp_cnt_q <= samp_cnt_q + SAMPLE_N'(1);
            end
         end

         assign samp = &samp_cnt_q;
      end
   endgenerate

   // ------------------------------------------------------------------------
   // Post-reset priming. A button still held through reset must first be
   // seen released. The cleared shift registers look like "released", so a
   // release only counts once the registers contain real samples.
   // ------------------------------------------------------------------------
   logic [PRIME_W-1:0] prime_cnt_q;
   logic               primed;

   assign primed = (prime_cnt_q == PRIME_W'(PRIME_CNT));

   always_ff @(posedge clk) begin
      if (!rst) begin
         prime_cnt_q <= '0;
      end else if (samp && !primed) begin
         prime_cnt_q <= prime_cnt_q + PRIME_W'(1);
      end
   end

   // ------------------------------------------------------------------------
   // Per-button synchroniser, debouncer and press FSM.
   // Index 0 is the enable button and index 1 is the direction button.
   // ------------------------------------------------------------------------
   logic [1:0] btn_raw;
   logic [1:0] level_w;
   logic [1:0] pulse_w;

   assign btn_raw = {btn_dir, btn_en};

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_btn
         logic             sync1_q;
         logic             sync2_q;
         logic [DEB_N-1:0] shift_q;
         logic             deb_q;
         logic             armed_q;
         logic             armed_d;
         logic [0:0]       state_q;
         logic [0:0]       state_d;
         logic             level_q;
         logic             level_d;
         logic             pulse_q;
         logic             pulse_d;

         always_comb begin
            state_d = state_q;
            level_d = level_q;
            pulse_d = 1'b0;
            armed_d = armed_q | (primed && (shift_q == '0));
            case (state_q)
               ST_RELEASED: begin
                  if (deb_q && armed_q) begin
                     state_d = ST_PRESSED;
                     pulse_d = 1'b1;
                     level_d = ~level_q;
                  end
               end
               ST_PRESSED: begin
                  if (!deb_q) begin
                     state_d = ST_RELEASED;
                  end
               end
               default: state_d = ST_RELEASED;
            endcase
         end

         always_ff @(posedge clk) begin
            if (!rst) begin
               sync1_q <= 1'b0;
               sync2_q <= 1'b0;
               shift_q <= '0;
               deb_q   <= 1'b0;
               armed_q <= 1'b0;
               state_q <= ST_RELEASED;
               level_q <= 1'b0;
               pulse_q <= 1'b0;
            end else begin
               sync1_q <= btn_raw[gi];
               sync2_q <= sync1_q;
               if (samp) begin
                  shift_q <= (shift_q << 1) | DEB_N'(sync2_q);
               end
               // A level changes only on a full run of equal samples.
               // Otherwise it holds.
               if (&shift_q) begin
                  deb_q <= 1'b1;
               end else if (shift_q == '0) begin
                  deb_q <= 1'b0;
               end
               armed_q <= armed_d;
               state_q <= state_d;
               level_q <= level_d;
               pulse_q <= pulse_d;
            end
         end

         assign level_w[gi] = level_q;
         assign pulse_w[gi] = pulse_q;
      end
   endgenerate

   // ------------------------------------------------------------------------
   // Step clock-enable. The counter holds its value while disabled, so
   // re-enabling resumes the current period instead of restarting it.
   // ------------------------------------------------------------------------
   logic [DIV_N-1:0] step_cnt_q;
   logic             step_tick_q;

   always_ff @(posedge clk) begin
      if (!rst) begin
         step_cnt_q  <= '0;
         step_tick_q <= 1'b0;
      end else begin
         step_tick_q <= 1'b0;
         if (level_w[0]) begin
            step_cnt_q  <= step_cnt_q + DIV_N'(1);
            step_tick_q <= &step_cnt_q;
         end
      end
   end

   assign en        = level_w[0];
   assign dir       = level_w[1];
   assign en_pulse  = pulse_w[0];
   assign dir_pulse = pulse_w[1];
   assign step_tick = step_tick_q;

endmodule

// File: tb/tb_button_ctrl.sv
// ============================================================================
// tb_button_ctrl
// ----------------------------------------------------------------------------
// Scoreboard bench for button_ctrl (DIV_N=3, SAMPLE_N=0, DEB_N=3).
// The stimulus script pushes the expected pulse and tick events, keyed by
// clock cycle, at the time it drives each press. The negedge monitor pops
// them as the cycles arrive. Any output pulse on a cycle with no queued
// event is an error.
// ============================================================================
module tb_button_ctrl;

   logic clk;
   logic rst;
   logic btn_en;
   logic btn_dir;
   logic en;
   logic dir;
   logic en_pulse;
   logic dir_pulse;
   logic step_tick;

   button_ctrl #(
      .DIV_N   (3),
      .SAMPLE_N(0),
      .DEB_N   (3)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .btn_en   (btn_en),
      .btn_dir  (btn_dir),
      .en       (en),
      .dir      (dir),
      .en_pulse (en_pulse),
      .dir_pulse(dir_pulse),
      .step_tick(step_tick)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int tests_run    = 0;
   int tests_failed = 0;

   task automatic check_val(input string tag, input logic [31:0] act,
                            input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cyc %0d)",
                  tag, act, exp, cyc);
      end
   endtask

   typedef struct {
      int cyc;
      bit ep;
      bit dp;
      bit tk;
      bit en_l;
      bit dir_l;
   } ev_t;

   ev_t sb_q[$];

   // Insert an event in cycle order. Events on the same cycle are merged.
   task automatic sb_push(input int c, input bit ep, input bit dp,
                          input bit tk, input bit en_l, input bit dir_l);
      ev_t e;
      int  idx;
      idx = sb_q.size();
      for (int i = 0; i < sb_q.size(); i++) begin
         if (sb_q[i].cyc == c) begin
            e = sb_q[i];
            e.ep = e.ep | ep;
            e.dp = e.dp | dp;
            e.tk = e.tk | tk;
            if (ep || dp) begin
               e.en_l  = en_l;
               e.dir_l = dir_l;
            end
            sb_q[i] = e;
            return;
         end
         if (sb_q[i].cyc > c) begin
            idx = i;
            break;
         end
      end
      e.cyc   = c;
      e.ep    = ep;
      e.dp    = dp;
      e.tk    = tk;
      e.en_l  = en_l;
      e.dir_l = dir_l;
      sb_q.insert(idx, e);
   endtask

   // Monitor: samples on the falling edge, half a cycle after outputs update.
   always @(negedge clk) begin : mon
      logic [2:0] obs;
      ev_t        e;
      obs = {en_pulse, dir_pulse, step_tick};
      while (sb_q.size() > 0 && sb_q[0].cyc < cyc) begin
         e = sb_q.pop_front();
         check_val("missed_evt_cyc", 32'(cyc), 32'(e.cyc));
      end
      if (sb_q.size() > 0 && sb_q[0].cyc == cyc) begin
         e = sb_q.pop_front();
         $display("[TB] cyc %0d event: en_pulse=%0b dir_pulse=%0b tick=%0b en=%0b dir=%0b",
                  cyc, en_pulse, dir_pulse, step_tick, en, dir);
         check_val("evt_outputs", 32'(obs), 32'({e.ep, e.dp, e.tk}));
         if (e.ep || e.dp) begin
            check_val("evt_levels", 32'({en, dir}), 32'({e.en_l, e.dir_l}));
         end
      end else begin
         check_val("quiet_outputs", 32'(obs), 32'(0));
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin : watchdog
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      int          c;
      logic [6:0]  pat;
      rst     = 1'b0;
      btn_en  = 1'b0;
      btn_dir = 1'b0;

      // 1: reset with toggling buttons, then release reset
      step(1);
      for (int i = 0; i < 2; i++) begin
         btn_en  = ~btn_en;
         btn_dir = (i == 0);
         step(1);
      end
      check_val("rst_outs", 32'({en, dir, en_pulse, dir_pulse, step_tick}), 32'(0));
      rst     = 1'b1;
      btn_en  = 1'b0;
      btn_dir = 1'b0;
      step(3);
      check_val("post_rst_outs", 32'({en, dir, en_pulse, dir_pulse, step_tick}), 32'(0));
      step(7);

      // 2 + 4a: clean en press. Ticks every 8 cycles until en is pressed
      // again 37 cycles later. That leaves the step counter at 37 mod 8 = 5.
      c = cyc;
      btn_en = 1'b1;
      sb_push(c + 7, 1, 0, 0, 1, 0);
      for (int m = 1; m <= 4; m++) sb_push(c + 7 + 8 * m, 0, 0, 1, 0, 0);
      sb_push(c + 44, 1, 0, 0, 0, 0);
      step(6);
      check_val("t2_en_before_latency", 32'(en), 32'(0));
      step(1);
      check_val("t2_en_after_latency", 32'(en), 32'(1));
      step(13);
      btn_en = 1'b0;
      step(17);
      btn_en = 1'b1;
      step(10);
      btn_en = 1'b0;
      step(10);
      check_val("t4_en_off", 32'(en), 32'(0));

      // 3: bounce on dir (longest run of ones is 2), then a real press
      pat = 7'b1011010;
      for (int i = 6; i >= 0; i--) begin
         btn_dir = pat[i];
         step(1);
      end
      btn_dir = 1'b0;
      step(10);
      check_val("t3_bounce_dir", 32'(dir), 32'(0));
      c = cyc;
      btn_dir = 1'b1;
      sb_push(c + 7, 0, 1, 0, 0, 1);
      step(5);
      btn_dir = 1'b0;
      step(12);
      check_val("t3_dir_set", 32'(dir), 32'(1));

      // 4b: re-enable from a held count of 5. First tick 3 cycles after en.
      c = cyc;
      btn_en = 1'b1;
      sb_push(c + 7, 1, 0, 0, 1, 1);
      sb_push(c + 10, 0, 0, 1, 0, 0);
      sb_push(c + 18, 0, 0, 1, 0, 0);
      sb_push(c + 26, 0, 0, 1, 0, 0);
      step(8);
      btn_en = 1'b0;
      step(12);

      // 5: simultaneous press of both buttons. Both levels return to 0.
      c = cyc;
      btn_en  = 1'b1;
      btn_dir = 1'b1;
      sb_push(c + 7, 1, 1, 0, 0, 0);
      step(8);
      btn_en  = 1'b0;
      btn_dir = 1'b0;
      step(12);
      check_val("t5_en", 32'(en), 32'(0));
      check_val("t5_dir", 32'(dir), 32'(0));

      // 6: reset while enabled with the counter at 5 and btn_en still held
      c = cyc;
      btn_en = 1'b1;
      sb_push(c + 7, 1, 0, 0, 1, 0);
      step(11);
      rst = 1'b0;
      step(1);
      check_val("t6_rst_outs", 32'({en, dir, en_pulse, dir_pulse, step_tick}), 32'(0));
      rst = 1'b1;
      step(20);
      check_val("t6_held_en", 32'(en), 32'(0));
      btn_en = 1'b0;
      step(10);
      c = cyc;
      btn_en = 1'b1;
      sb_push(c + 7, 1, 0, 0, 1, 0);
      sb_push(c + 15, 0, 0, 1, 0, 0);
      step(10);
      btn_en = 1'b0;
      step(8);

      @(negedge clk);
      #1;
      check_val("sb_empty", 32'(sb_q.size()), 32'(0));
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
